regc_arbiter: RTL
=================

# regc_arbiter

Round-robin write arbiter and sequencer for Register C. It shares the single `load_c`/`data_in_c` write port of Register C between `NUM_REQ` requesters using per-requester valid/ready handshakes. It tracks each accepted write through Register C's fixed two-stage output pipeline and returns a response tagged with the requester id when that write's data reaches `data_out_c1`. It sits between the requesting datapath units and Register C, and also provides a flush/drain sequence for pipeline quiescence.

## Interface
- `DATA_WIDTH`, 32: width of the data word; must match Register C.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PIPE_LAT`, 2: cycles from `load_c` high to that data appearing on Register C `data_out_c1`.
- `ID_W`, `$clog2(NUM_REQ)`: width of requester id.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot grant, combinational; a transfer happens on `req_valid[i] & req_ready[i]`.
- `load_c`  out  1  to Register C.
- `data_in_c`  out  DATA_WIDTH  to Register C.
- `resp_valid`  out  1  one-cycle pulse; `data_out_c1` now holds the tagged write.
- `resp_id`  out  ID_W  requester id for `resp_valid`.
- `flush_req`  in  1  level request to stop accepting writes and drain.
- `flush_done`  out  1  one-cycle pulse when the drain completes.
- `busy`  out  1  high when any write is in flight (`load_c` or tracker non-empty).

## Operation
- FSM states:
  - ACCEPT (reset state)
  - DRAIN
  - DONE
- ACCEPT behaviour:
  - Arbitration runs every cycle.
  - The winner is the first index with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready` is one-hot on the winner; all zeros when no request is present.
  - On a transfer, `rr_ptr` becomes winner+1, wrapping NUM_REQ-1 to 0.
- ACCEPT → DRAIN when `flush_req` = 1. In that cycle `req_ready` = 0 and no transfer occurs; `flush_req` has priority over requests in the same cycle.
- DRAIN behaviour: `req_ready` = 0. Move to DONE when there is no `load_c` and the tracker is empty.
- DONE behaviour: `flush_done` = 1 for exactly one cycle.
  - Returns to ACCEPT if `flush_req` = 0.
  - Otherwise holds in DONE with `flush_done` low until `flush_req` drops.
- Write path: `load_c` and `data_in_c` are registered, loaded the cycle after a transfer. `load_c` is low in cycles with no transfer. `data_in_c` holds its last value when idle.
- Tracker: a PIPE_LAT-deep shift register of {valid, id} entries, advanced every cycle. An entry enters alongside `load_c`. `resp_valid`/`resp_id` come from the tracker tail.
- Back-to-back writes are legal at one per cycle; responses come out in acceptance order, one per cycle.

## Timing
- Transfer in cycle N → `load_c` high in cycle N+1 → `resp_valid` in cycle N+1+PIPE_LAT (N+3 at default).
- Throughput: one write per cycle.
- Reset (asynchronous assert, synchronous release):
  - FSM returns to ACCEPT, `rr_ptr` = 0.
  - `load_c`, `resp_valid`, `flush_done`, `busy` = 0.
  - `data_in_c`, `resp_id` = 0; tracker cleared.
  - `req_ready` = 0 while `reset` is low.
- Reset mid-operation drops all in-flight responses; no `resp_valid` is emitted for them.
- `flush_req` while idle: DRAIN lasts one cycle, `flush_done` comes 2 cycles after `flush_req` is first seen.
- `flush_req` one cycle after a transfer: `flush_done` comes in the cycle after that write's `resp_valid`.

## Configuration
- `REGC_ARB_LOCK_EN` defined:
  - Adds input `req_lock` [NUM_REQ].
  - If the winner has `req_lock` set at transfer, `rr_ptr` stays on the winner, so it keeps priority for consecutive writes.
  - The lock is ignored in DRAIN.
- `REGC_ARB_LOCK_EN` undefined: port absent; pure round-robin.

## Test plan
- Reset with `req_valid`=4'b1111 held → after release, grants go 0,1,2,3,0 on consecutive cycles; `load_c` is continuous from the cycle after the first grant.
- Single request from requester 2 with data 32'hDEADBEEF in cycle 10 → `load_c`=1, `data_in_c`=32'hDEADBEEF in cycle 11; `resp_valid`=1, `resp_id`=2 in cycle 13, while `data_out_c1`=32'hDEADBEEF.
- Requesters 1 and 3 valid with `rr_ptr`=2 → 3 is granted first, then 1; responses come out in order 3, 1 on consecutive cycles.
- `flush_req`=1 arriving together with `req_valid`=4'b0001 → no grant; once the tracker has drained, `flush_done` pulses once; after `flush_req` drops, requester 0 is granted.
- `reset` asserted one cycle after a transfer → `load_c`=0 and `resp_valid`=0 immediately; no response appears for that write after release.
- With `REGC_ARB_LOCK_EN`: requester 1 holds `req_lock`=1 and `req_valid`=1 while requester 2 also requests → requester 1 wins every cycle; when it drops the lock, requester 2 is granted in the next cycle.

Source files
------------

// File: rtl/regc_arbiter.sv
// Round-robin write arbiter for Register C with a response tracker and a flush/drain sequencer.
// Optional macro REGC_ARB_LOCK_EN adds req_lock so a granted requester can keep priority.
module regc_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int PIPE_LAT   = 2,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef REGC_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          load_c,
   output logic [DATA_WIDTH-1:0]         data_in_c,
   output logic                          resp_valid,
   output logic [ID_W-1:0]               resp_id,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic                          busy
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      DRAIN  = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic                  done_held;

   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       rr_ptr_next;
   logic [ID_W-1:0]       win;
   logic                  found;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  transfer;
   logic                  ptr_hold;

   logic [PIPE_LAT-1:0]   trk_valid;
   logic [ID_W-1:0]       trk_id [PIPE_LAT];

   // Search upward from rr_ptr, wrapping, for the first valid requester.
   always_comb begin
      int idx;
      found    = 1'b0;
      win      = '0;
      win_data = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req_valid[ID_W'(idx)]) begin
            found    = 1'b1;
            win      = ID_W'(idx);
            win_data = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ACCEPT;
         done_held <= 1'b0;
      end else begin
         state     <= state_next;
         done_held <= (state == DONE);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCEPT: begin
            if (flush_req) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!load_c && !(|trk_valid)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!flush_req) begin
               state_next = ACCEPT;
            end
         end
         default: state_next = ACCEPT;
      endcase
   end

   // Grants are gated by reset so nothing can be accepted while the block is held in reset.
   always_comb begin
      req_ready  = '0;
      flush_done = 1'b0;
      if (state == ACCEPT && !flush_req && reset && found) begin
         req_ready[win] = 1'b1;
      end
      if (state == DONE && !done_held) begin
         flush_done = 1'b1;
      end
   end

   assign transfer = |(req_valid & req_ready);

`ifdef REGC_ARB_LOCK_EN
   assign ptr_hold = req_lock[win] && (state == ACCEPT);
`else
   assign ptr_hold = 1'b0;
`endif

   always_comb begin
      rr_ptr_next = rr_ptr;
      if (transfer) begin
         if (ptr_hold) begin
            rr_ptr_next = win;
         end else if (win == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
         end else begin
            rr_ptr_next = win + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         load_c    <= 1'b0;
         data_in_c <= '0;
      end else begin
         rr_ptr <= rr_ptr_next;
         load_c <= transfer;
         if (transfer) begin
            data_in_c <= win_data;
         end
      end
   end

   // Tracker head fills alongside load_c; the registered tail lines up with data_out_c1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trk_valid  <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            trk_id[i] <= '0;
         end
      end else begin
         trk_valid[0] <= transfer;
         trk_id[0]    <= win;
         for (int i = 1; i < PIPE_LAT; i++) begin
            trk_valid[i] <= trk_valid[i-1];
            trk_id[i]    <= trk_id[i-1];
         end
         resp_valid <= trk_valid[PIPE_LAT-1];
         if (trk_valid[PIPE_LAT-1]) begin
            resp_id <= trk_id[PIPE_LAT-1];
         end
      end
   end

   assign busy = load_c | (|trk_valid);

endmodule
